rr_response_router: RTL and testbench

- Downstream companion of the round-robin PLM scheduling kernel.
- Each cycle it records, per kernel (bank × port), which consumer was granted and whether the access was a read or a write.
- It delays those tags by the PLM read latency and steers each kernel's PLM read data back to the granting consumer with a one-cycle valid pulse.
- It gives each consumer a registered write-acknowledge and flags routing collisions.

---
 rtl/rr_response_router.sv | 162 ++++++++++++++++
 tb/tb_rr_response_router.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_response_router.sv
// Response router behind the round-robin PLM scheduler. It tracks each kernel's grants
// through the PLM read latency and returns read data, write acks and a collision flag.

module assert_true #(
    parameter bit    COND = 1'b1,
    parameter string MSG  = "parameter check failed"
) ();
    if (!COND) begin : g_fail
        $fatal(1, "%s", MSG);
    end
endmodule

module rr_response_router #(
    parameter int VALUE_WIDTH = 8,
    parameter int NCONSUMERS  = 2,
    parameter int NBANKS      = 1,
    parameter int NPORTS      = 1,
    parameter int PLM_LATENCY = 1,
    localparam int NKERNELS   = NBANKS * NPORTS,
    localparam int CID_WIDTH  = $clog2(NCONSUMERS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NKERNELS-1:0]               grant_valid,
    input  logic [NKERNELS*CID_WIDTH-1:0]     grant_cid,
    input  logic [NKERNELS-1:0]               grant_wr,
    input  logic [NKERNELS*VALUE_WIDTH-1:0]   plm_outputs,
    output logic [NCONSUMERS-1:0]             resp_valid,
    output logic [NCONSUMERS*VALUE_WIDTH-1:0] resp_data,
    output logic [NCONSUMERS-1:0]             wr_ack,
    output logic                              collision
);

    assert_true #(.COND(NPORTS == 1 || NPORTS == 2),
                  .MSG("rr_response_router: NPORTS must be 1 or 2")) u_chk_nports ();
    assert_true #(.COND(PLM_LATENCY >= 1 && PLM_LATENCY <= 4),
                  .MSG("rr_response_router: PLM_LATENCY must be 1..4")) u_chk_latency ();
    assert_true #(.COND(NCONSUMERS >= 2),
                  .MSG("rr_response_router: NCONSUMERS must be >= 2")) u_chk_nconsumers ();
    assert_true #(.COND(NKERNELS > 1),
                  .MSG("rr_response_router: NBANKS*NPORTS must be > 1")) u_chk_nkernels ();

    function automatic logic [CID_WIDTH-1:0] kernel_cid(
        input logic [NKERNELS*CID_WIDTH-1:0] vec,
        input int                            k
    );
        return vec[k*CID_WIDTH +: CID_WIDTH];
    endfunction

    // Non-power-of-two consumer counts leave unused encodings that must be rejected.
    function automatic logic cid_in_range(input logic [CID_WIDTH-1:0] cid);
        return (32'(cid) < NCONSUMERS);
    endfunction

    logic [NKERNELS-1:0]           tag_valid_r [PLM_LATENCY];
    logic [NKERNELS*CID_WIDTH-1:0] tag_cid_r   [PLM_LATENCY];

    logic [NKERNELS-1:0]             cap_valid_s;
    logic [NKERNELS-1:0]             exit_valid_s;
    logic [NKERNELS*CID_WIDTH-1:0]   exit_cid_s;
    logic [NCONSUMERS-1:0]           resp_valid_s;
    logic [NCONSUMERS*VALUE_WIDTH-1:0] resp_data_s;
    logic                            rd_collide_s;
    logic [NCONSUMERS-1:0]           wr_hit_s;
    logic                            wr_collide_s;
    logic                            oob_s;
    logic [NCONSUMERS-1:0]           wr_ack_r;
    logic                            collision_r;

    // Only in-range read grants produce a tag; writes are acknowledged separately.
    always_comb begin
        cap_valid_s = '0;
        for (int k = 0; k < NKERNELS; k++) begin
            cap_valid_s[k] = grant_valid[k] && !grant_wr[k]
                             && cid_in_range(kernel_cid(grant_cid, k));
        end
    end

    // Per-kernel tag delay line, shifting every cycle to track the PLM read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < PLM_LATENCY; s++) begin
                tag_valid_r[s] <= '0;
                tag_cid_r[s]   <= '0;
            end
        end else begin
            tag_valid_r[0] <= cap_valid_s;
            tag_cid_r[0]   <= grant_cid;
            for (int s = 1; s < PLM_LATENCY; s++) begin
                tag_valid_r[s] <= tag_valid_r[s-1];
                tag_cid_r[s]   <= tag_cid_r[s-1];
            end
        end
    end

    assign exit_valid_s = tag_valid_r[PLM_LATENCY-1];
    assign exit_cid_s   = tag_cid_r[PLM_LATENCY-1];

    // Steer exiting read data to its consumer; scanning upward lets the lowest kernel win.
    always_comb begin
        resp_valid_s = '0;
        resp_data_s  = '0;
        rd_collide_s = 1'b0;
        for (int c = 0; c < NCONSUMERS; c++) begin
            for (int k = 0; k < NKERNELS; k++) begin
                if (exit_valid_s[k] && (kernel_cid(exit_cid_s, k) == CID_WIDTH'(c))) begin
                    if (resp_valid_s[c]) begin
                        rd_collide_s = 1'b1;
                    end else begin
                        resp_valid_s[c]                         = 1'b1;
                        resp_data_s[c*VALUE_WIDTH +: VALUE_WIDTH] =
                            plm_outputs[k*VALUE_WIDTH +: VALUE_WIDTH];
                    end
                end else begin
                    rd_collide_s = rd_collide_s;
                end
            end
        end
    end

    // Decode this cycle's write grants and any grant naming a nonexistent consumer.
    always_comb begin
        wr_hit_s     = '0;
        wr_collide_s = 1'b0;
        oob_s        = 1'b0;
        for (int k = 0; k < NKERNELS; k++) begin
            if (grant_valid[k] && !cid_in_range(kernel_cid(grant_cid, k))) begin
                oob_s = 1'b1;
            end else begin
                oob_s = oob_s;
            end
        end
        for (int c = 0; c < NCONSUMERS; c++) begin
            for (int k = 0; k < NKERNELS; k++) begin
                if (grant_valid[k] && grant_wr[k]
                    && (kernel_cid(grant_cid, k) == CID_WIDTH'(c))) begin
                    wr_collide_s = wr_collide_s | wr_hit_s[c];
                    wr_hit_s[c]  = 1'b1;
                end else begin
                    wr_collide_s = wr_collide_s;
                end
            end
        end
    end

    // Write acks pulse one cycle after the grant; collision stays set until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ack_r    <= '0;
            collision_r <= 1'b0;
        end else begin
            wr_ack_r    <= wr_hit_s;
            collision_r <= collision_r | rd_collide_s | wr_collide_s | oob_s;
        end
    end

    assign resp_valid = resp_valid_s;
    assign resp_data  = resp_data_s;
    assign wr_ack     = wr_ack_r;
    assign collision  = collision_r;

endmodule

// File: tb/tb_rr_response_router.sv
// Bench for rr_response_router: 3 consumers, 2 kernels (dual-port bank), PLM latency 3.
// Directed table, hand sequences and random traffic, all checked against a cycle-history model.

module tb_rr_response_router;

    localparam int NK   = 2;
    localparam int NC   = 3;
    localparam int L    = 3;
    localparam int VW   = 8;
    localparam int CW   = 2;
    localparam int HMAX = 1024;

    logic            clk = 1'b0;
    logic            reset;
    logic [NK-1:0]   grant_valid;
    logic [NK*CW-1:0] grant_cid;
    logic [NK-1:0]   grant_wr;
    logic [NK*VW-1:0] plm_outputs;
    logic [NC-1:0]   resp_valid;
    logic [NC*VW-1:0] resp_data;
    logic [NC-1:0]   wr_ack;
    logic            collision;

    rr_response_router #(
        .VALUE_WIDTH(VW), .NCONSUMERS(NC), .NBANKS(1), .NPORTS(2), .PLM_LATENCY(L)
    ) dut (
        .clk(clk), .reset(reset),
        .grant_valid(grant_valid), .grant_cid(grant_cid), .grant_wr(grant_wr),
        .plm_outputs(plm_outputs),
        .resp_valid(resp_valid), .resp_data(resp_data), .wr_ack(wr_ack),
        .collision(collision)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model: full history of grants by absolute cycle number
    logic [NK-1:0]    h_v   [HMAX];
    logic [NK-1:0]    h_w   [HMAX];
    logic [NK*CW-1:0] h_cid [HMAX];
    int  cyc      = 0;
    int  last_rst = -1;
    bit  m_coll   = 1'b0;
    bit  pend_ev  = 1'b0;

    typedef struct {
        logic [1:0]  gv;
        logic [1:0]  gw;
        logic [3:0]  gcid;
        logic [15:0] plm;
        logic [2:0]  rv;
        logic [23:0] rd;
        logic [2:0]  wa;
        logic        coll;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive_and_check(input logic [1:0] v, input logic [1:0] w,
                                   input logic [3:0] cid, input logic [15:0] plm,
                                   input bit rst);
        logic [NC-1:0]    exp_rv;
        logic [NC*VW-1:0] exp_rd;
        logic [NC-1:0]    exp_wa;
        bit ev;
        int src;
        reset       = rst;
        grant_valid = v;
        grant_wr    = w;
        grant_cid   = cid;
        plm_outputs = plm;
        #2;
        h_v[cyc]   = v;
        h_w[cyc]   = w;
        h_cid[cyc] = cid;
        if (rst) begin
            last_rst = cyc;
            m_coll   = 1'b0;
        end
        exp_rv = '0;
        exp_rd = '0;
        exp_wa = '0;
        ev     = 1'b0;
        src    = cyc - L;
        for (int c = 0; c < NC; c++) begin
            int hits;
            hits = 0;
            if (src >= 0 && src > last_rst) begin
                for (int k = 0; k < NK; k++) begin
                    if (h_v[src][k] && !h_w[src][k] && int'(h_cid[src][k*CW +: CW]) == c) begin
                        if (hits == 0) begin
                            exp_rv[c]          = 1'b1;
                            exp_rd[c*VW +: VW] = plm[k*VW +: VW];
                        end
                        hits++;
                    end
                end
            end
            if (hits > 1) ev = 1'b1;
            hits = 0;
            if (cyc - 1 > last_rst) begin
                for (int k = 0; k < NK; k++) begin
                    if (h_v[cyc-1][k] && h_w[cyc-1][k] && int'(h_cid[cyc-1][k*CW +: CW]) == c)
                        hits++;
                end
            end
            exp_wa[c] = (hits > 0);
            hits = 0;
            for (int k = 0; k < NK; k++) begin
                if (!rst && v[k] && w[k] && int'(cid[k*CW +: CW]) == c) hits++;
            end
            if (hits > 1) ev = 1'b1;
        end
        for (int k = 0; k < NK; k++) begin
            if (!rst && v[k] && int'(cid[k*CW +: CW]) >= NC) ev = 1'b1;
        end
        pend_ev = ev;
        check("model_resp_valid", 32'(resp_valid), 32'(exp_rv));
        check("model_resp_data",  32'(resp_data),  32'(exp_rd));
        check("model_wr_ack",     32'(wr_ack),     32'(exp_wa));
        check("model_collision",  32'(collision),  32'(m_coll));
    endtask

    task automatic advance();
        @(posedge clk);
        m_coll = m_coll | pend_ev;
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input logic [15:0] plm);
        drive_and_check(2'b00, 2'b00, 4'b0000, plm, 1'b0);
    endtask

    initial begin
        // gv, gw, gcid{k1,k0}, plm{k1,k0} | rv, rd{c2,c1,c0}, wa, coll
        tbl[0]  = '{2'b11, 2'b00, 4'b0001, 16'h0000, 3'b000, 24'h000000, 3'b000, 1'b0};
        tbl[1]  = '{2'b11, 2'b01, 4'b0010, 16'h0000, 3'b000, 24'h000000, 3'b000, 1'b0};
        tbl[2]  = '{2'b10, 2'b00, 4'b0000, 16'h0000, 3'b000, 24'h000000, 3'b100, 1'b0};
        tbl[3]  = '{2'b01, 2'b01, 4'b0000, 16'h11A5, 3'b011, 24'h00A511, 3'b000, 1'b0};
        tbl[4]  = '{2'b00, 2'b00, 4'b0000, 16'h2277, 3'b001, 24'h000022, 3'b001, 1'b0};
        tbl[5]  = '{2'b11, 2'b00, 4'b0101, 16'h3300, 3'b001, 24'h000033, 3'b000, 1'b0};
        tbl[6]  = '{2'b00, 2'b00, 4'b0000, 16'h6B5A, 3'b000, 24'h000000, 3'b000, 1'b0};
        tbl[7]  = '{2'b00, 2'b00, 4'b0000, 16'h0000, 3'b000, 24'h000000, 3'b000, 1'b0};
        tbl[8]  = '{2'b00, 2'b00, 4'b0000, 16'hF00F, 3'b010, 24'h000F00, 3'b000, 1'b0};
        tbl[9]  = '{2'b00, 2'b00, 4'b0000, 16'h0000, 3'b000, 24'h000000, 3'b000, 1'b1};
        tbl[10] = '{2'b11, 2'b11, 4'b1010, 16'h0000, 3'b000, 24'h000000, 3'b000, 1'b1};
        tbl[11] = '{2'b00, 2'b00, 4'b0000, 16'h0000, 3'b000, 24'h000000, 3'b100, 1'b1};
        tbl[12] = '{2'b00, 2'b00, 4'b0000, 16'h0000, 3'b000, 24'h000000, 3'b000, 1'b1};

        reset       = 1'b1;
        grant_valid = '0;
        grant_wr    = '0;
        grant_cid   = '0;
        plm_outputs = '0;
        @(negedge clk);

        // reset state
        drive_and_check(2'b00, 2'b00, 4'b0000, 16'hFFFF, 1'b1);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_resp_data",  32'(resp_data),  32'd0);
        check("reset_wr_ack",     32'(wr_ack),     32'd0);
        check("reset_collision",  32'(collision),  32'd0);
        advance();

        // directed table: round trip, latency sweep, write ack, mixed traffic, read collision
        for (int i = 0; i < 13; i++) begin
            drive_and_check(tbl[i].gv, tbl[i].gw, tbl[i].gcid, tbl[i].plm, 1'b0);
            check($sformatf("tbl%0d_resp_valid", i), 32'(resp_valid), 32'(tbl[i].rv));
            check($sformatf("tbl%0d_resp_data", i),  32'(resp_data),  32'(tbl[i].rd));
            check($sformatf("tbl%0d_wr_ack", i),     32'(wr_ack),     32'(tbl[i].wa));
            check($sformatf("tbl%0d_collision", i),  32'(collision),  32'(tbl[i].coll));
            advance();
        end

        // reset mid-flight: read grant, then reset (with a grant during reset)
        drive_and_check(2'b01, 2'b00, 4'b0000, 16'h0000, 1'b0);
        advance();
        drive_and_check(2'b10, 2'b00, 4'b0100, 16'hC33C, 1'b1);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_resp_data",  32'(resp_data),  32'd0);
        check("midrst_wr_ack",     32'(wr_ack),     32'd0);
        check("midrst_collision",  32'(collision),  32'd0);
        advance();
        for (int i = 0; i < 4; i++) begin
            idle(16'hC33C);
            check("postrst_no_resp", 32'(resp_valid), 32'd0);
            advance();
        end

        // simultaneous writes to one consumer: single ack, collision rises
        drive_and_check(2'b11, 2'b11, 4'b0101, 16'h0000, 1'b0);
        check("wcol_pre_collision", 32'(collision), 32'd0);
        advance();
        idle(16'h0000);
        check("wcol_ack",       32'(wr_ack),    32'b010);
        check("wcol_collision", 32'(collision), 32'd1);
        advance();
        idle(16'h0000);
        check("wcol_ack_single", 32'(wr_ack), 32'd0);
        advance();

        // out-of-range consumer index: dropped, collision set
        drive_and_check(2'b00, 2'b00, 4'b0000, 16'h0000, 1'b1);
        advance();
        drive_and_check(2'b11, 2'b10, 4'b1111, 16'h0000, 1'b0);
        advance();
        idle(16'h0000);
        check("oob_collision", 32'(collision), 32'd1);
        check("oob_no_ack",    32'(wr_ack),    32'd0);
        advance();
        idle(16'h0000);
        advance();
        idle(16'hEEDD);
        check("oob_no_resp", 32'(resp_valid), 32'd0);
        advance();

        // randomized traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            logic [1:0] v, w;
            logic [3:0] cid;
            bit rst;
            rst = ($urandom_range(0, 39) == 0);
            v   = 2'($urandom_range(0, 3));
            w   = 2'($urandom_range(0, 3));
            for (int k = 0; k < NK; k++) begin
                cid[k*CW +: CW] = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            end
            drive_and_check(v, w, cid, 16'($urandom), rst);
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
